// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_pkg
//  Description : Shared branch-predictor definitions: 2-bit counter
//                encodings and saturating counter helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package bpu_pkg;

  // 2-bit saturating counter states
  localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

  // Increment, holding at strongly-taken
  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    return (cnt == CNT_ST) ? CNT_ST : cnt + 2'b01;
  endfunction

  // Decrement, holding at strongly-not-taken
  function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bpu_btb.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_btb
//  Description : Direct-mapped branch target buffer with per-entry 2-bit
//                counter and jump flag. One combinational lookup port, one
//                clocked update port driven by the resolving instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  // lookup port
  input  logic [XLEN-1:0] lu_pc,
  output logic            lu_hit,
  output logic            lu_jump,
  output logic [1:0]      lu_cnt,
  output logic [XLEN-1:0] lu_target,
  // update port
  input  logic            upd_valid,
  input  logic            upd_is_cti,
  input  logic            upd_is_jump,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  logic            r_jump   [ENTRIES];
  logic [1:0]      r_cnt    [ENTRIES];

  logic [IDXW-1:0] w_lu_idx;
  logic [TAGW-1:0] w_lu_tag;
  logic [IDXW-1:0] w_upd_idx;
  logic [TAGW-1:0] w_upd_tag;
  logic            w_upd_hit;
  logic            w_unused;

  // Instruction-aligned PCs: the low two bits never select an entry
  assign w_unused = ^{lu_pc[1:0], upd_pc[1:0]};

  // Lookup reads the stored entry as of the start of the cycle (no bypass)
  always_comb begin
    w_lu_idx  = lu_pc[IDXW+1:2];
    w_lu_tag  = lu_pc[XLEN-1:IDXW+2];
    lu_hit    = r_valid[w_lu_idx] && (r_tag[w_lu_idx] == w_lu_tag);
    lu_jump   = r_jump[w_lu_idx];
    lu_cnt    = r_cnt[w_lu_idx];
    lu_target = r_target[w_lu_idx];
  end

  // Hit detection for the resolving instruction
  always_comb begin
    w_upd_idx = upd_pc[IDXW+1:2];
    w_upd_tag = upd_pc[XLEN-1:IDXW+2];
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  end

  // Entry training, allocation and alias invalidation; reset wins over updates
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_jump[i]   <= 1'b0;
        r_cnt[i]    <= CNT_INIT;
      end
    end else if (upd_valid) begin
      if (upd_is_cti) begin
        if (w_upd_hit) begin
          if (upd_is_jump)
            r_cnt[w_upd_idx] <= CNT_ST;
          else if (upd_taken)
            r_cnt[w_upd_idx] <= sat_inc(r_cnt[w_upd_idx]);
          else
            r_cnt[w_upd_idx] <= sat_dec(r_cnt[w_upd_idx]);
          if (upd_taken)
            r_target[w_upd_idx] <= upd_target;
        end else if (upd_taken) begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= upd_target;
          r_jump[w_upd_idx]   <= upd_is_jump;
          r_cnt[w_upd_idx]    <= CNT_WT;
        end
      end else if (w_upd_hit) begin
        // A non-CTI matched an entry: the entry is a stale alias
        r_valid[w_upd_idx] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_bpu.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_bpu
//  Description : Fetch-stage PC generator with BTB-based dynamic branch
//                prediction, MEM-stage mispredict repair and perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_bpu
  import bpu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0,
  parameter logic [1:0]      CNT_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_is_cti,
  input  logic            upd_is_jump,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [31:0]     perf_cti,
  output logic [31:0]     perf_mispred
);

  localparam logic [31:0] c_perf_max = 32'hFFFF_FFFF;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_repair_pc;
  logic            w_hit;
  logic            w_jump;
  logic [1:0]      w_cnt;
  logic [31:0]     r_perf_cti;
  logic [31:0]     r_perf_mispred;
  logic            w_unused;

  bpu_btb #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .CNT_INIT (CNT_INIT)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lu_pc       (r_pc),
    .lu_hit      (w_hit),
    .lu_jump     (w_jump),
    .lu_cnt      (w_cnt),
    .lu_target   (pred_target),
    .upd_valid   (upd_valid),
    .upd_is_cti  (upd_is_cti),
    .upd_is_jump (upd_is_jump),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  // Only the counter MSB carries the direction
  assign w_unused = w_cnt[0];

  // Prediction and mispredict detection; low PC bits pass through the +4 adders
  always_comb begin
    pred_taken  = w_hit && (w_jump || w_cnt[1]);
    mispredict  = upd_valid &&
                  ((upd_is_cti && (upd_taken != upd_pred_taken)) ||
                   (upd_is_cti && upd_taken && (upd_target != upd_pred_target)) ||
                   (!upd_is_cti && upd_pred_taken));
    w_pc_seq    = {r_pc[XLEN-1:2] + (XLEN-2)'(1), r_pc[1:0]};
    w_repair_pc = (upd_taken && upd_is_cti) ? upd_target
                                            : {upd_pc[XLEN-1:2] + (XLEN-2)'(1), upd_pc[1:0]};
  end

  // Next-PC select: repair beats stall, stall beats prediction
  always_comb begin
    w_pc_next = r_pc;
    if (mispredict)
      w_pc_next = w_repair_pc;
    else if (stall)
      w_pc_next = r_pc;
    else if (pred_taken)
      w_pc_next = pred_target;
    else
      w_pc_next = w_pc_seq;
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (reset)
      r_pc <= RESET_PC;
    else
      r_pc <= w_pc_next;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cti     <= '0;
      r_perf_mispred <= '0;
    end else begin
      if (upd_valid && upd_is_cti && (r_perf_cti != c_perf_max))
        r_perf_cti <= r_perf_cti + 32'd1;
      if (mispredict && (r_perf_mispred != c_perf_max))
        r_perf_mispred <= r_perf_mispred + 32'd1;
    end
  end

  assign pc           = r_pc;
  assign perf_cti     = r_perf_cti;
  assign perf_mispred = r_perf_mispred;

endmodule
`default_nettype wire
